// File: rtl/bw_mul_pkg.sv
// Shared definitions for the pipelined Baugh-Wooley multiplier: final adder
// block size, the control word that travels alongside each beat, and the
// helpers that split the partial-product rows across pipeline stages.
package bw_mul_pkg;

    localparam int CSEL_BLK  = 4;
    // Widest tag the control word can carry; narrower tags are zero-extended.
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic                 valid;
        logic                 tc_mode;
        logic [TAG_W_MAX-1:0] tag;
    } ctrl_t;

    // Rows handled by stage s; the first (width % stages) stages take one extra row.
    function automatic int rows_in_stage(input int width, input int stages, input int s);
        return (width / stages) + ((s < (width % stages)) ? 1 : 0);
    endfunction

    // Index of the first row handled by stage s.
    function automatic int rows_before(input int width, input int stages, input int s);
        return (s * (width / stages)) + ((s < (width % stages)) ? s : (width % stages));
    endfunction

endpackage

// File: rtl/bw_mul_pipe_csa_rows.sv
// One stage's group of carry-save rows. The sum/carry pair is kept in a
// frame that slides up one bit per row, so each row retires one final low
// product bit and the vectors never grow beyond WIDTH bits.
module bw_csa_rows
    import bw_mul_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FIRST_ROW = 0,
    parameter int NUM_ROWS  = 8
) (
    input  logic [WIDTH-1:0]    sum_in,
    input  logic [WIDTH-1:0]    carry_in,
    input  logic [WIDTH-1:0]    a,
    input  logic [NUM_ROWS-1:0] b_rows,
    input  logic                tc_mode,
    output logic [WIDTH-1:0]    sum_out,
    output logic [WIDTH-1:0]    carry_out,
    output logic [NUM_ROWS-1:0] lo_bits
);

    // Fold each partial-product row into the carry-save pair, retiring bit 0 per row.
    always_comb begin
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] fs;
        logic [WIDTH-1:0] fc;
        logic             pp;
        s       = sum_in;
        c       = carry_in;
        fs      = '0;
        fc      = '0;
        pp      = 1'b0;
        lo_bits = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int i = 0; i < WIDTH; i++) begin
                pp = a[i] & b_rows[r];
                // Sign-weighted terms are inverted; the MSB x MSB term stays positive.
                if (tc_mode && (((FIRST_ROW + r) == (WIDTH - 1)) != (i == (WIDTH - 1))))
                    pp = ~pp;
                fs[i] = s[i] ^ c[i] ^ pp;
                fc[i] = (s[i] & c[i]) | (pp & (s[i] ^ c[i]));
            end
            lo_bits[r] = fs[0];
            s          = {1'b0, fs[WIDTH-1:1]};
            c          = fc;
        end
        sum_out   = s;
        carry_out = c;
    end

endmodule

// File: rtl/bw_mul_pipe.sv
// Pipelined Baugh-Wooley multiplier, signed or unsigned per beat.
// Input register -> STAGES carry-save row groups -> carry-select adder and
// output register. One global enable stalls every register together, so the
// pipeline depth is fixed and bubbles simply ride along.
module bw_mul_pipe
    import bw_mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 tc_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int NBLK  = (WIDTH + CSEL_BLK - 1) / CSEL_BLK;
    localparam int PAD_W = NBLK * CSEL_BLK;

    logic             en;
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    ctrl_t            ctrl_q  [STAGES+1];
    logic [WIDTH-1:0] sum_q   [1:STAGES];
    logic [WIDTH-1:0] carry_q [1:STAGES];
    logic [WIDTH-1:0] lo_q    [1:STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] carry_d [STAGES];
    logic [WIDTH-1:0] lo_d    [STAGES];
    logic [WIDTH-1:0] hi_sum;
    logic             unused_tag_hi;

    assign en            = !out_valid || out_ready;
    assign in_ready      = en;
    assign unused_tag_hi = ^ctrl_q[STAGES].tag;

    // Row groups: stage g consumes the operands and partial sums registered before it.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int FIRST = rows_before(WIDTH, STAGES, g);
        localparam int NROWS = rows_in_stage(WIDTH, STAGES, g);

        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] c_in;
        logic [WIDTH-1:0] lo_in;
        logic [NROWS-1:0] retired;

        if (g == 0) begin : g_head
            assign s_in  = '0;
            assign c_in  = '0;
            assign lo_in = '0;
        end else begin : g_body
            assign s_in  = sum_q[g];
            assign c_in  = carry_q[g];
            assign lo_in = lo_q[g];
        end

        bw_csa_rows #(
            .WIDTH     (WIDTH),
            .FIRST_ROW (FIRST),
            .NUM_ROWS  (NROWS)
        ) u_rows (
            .sum_in    (s_in),
            .carry_in  (c_in),
            .a         (a_q[g]),
            .b_rows    (b_q[g][FIRST +: NROWS]),
            .tc_mode   (ctrl_q[g].tc_mode),
            .sum_out   (sum_d[g]),
            .carry_out (carry_d[g]),
            .lo_bits   (retired)
        );

        // Retired low bits join the delay-matched low-half register of this beat.
        assign lo_d[g] = lo_in | (WIDTH'(retired) << FIRST);
    end

    // Upper half: carry-select add of the final sum/carry pair. The signed
    // correction's 2^WIDTH term enters as carry-in, its top-bit term as an MSB flip.
    always_comb begin
        logic [PAD_W-1:0]    x;
        logic [PAD_W-1:0]    y;
        logic [PAD_W-1:0]    r;
        logic [CSEL_BLK:0]   r0;
        logic [CSEL_BLK:0]   r1;
        logic                carry;
        x     = PAD_W'(sum_q[STAGES]);
        y     = PAD_W'(carry_q[STAGES]);
        r     = '0;
        r0    = '0;
        r1    = '0;
        carry = ctrl_q[STAGES].tc_mode;
        for (int blk = 0; blk < NBLK; blk++) begin
            r0 = {1'b0, x[blk*CSEL_BLK +: CSEL_BLK]} + {1'b0, y[blk*CSEL_BLK +: CSEL_BLK]};
            r1 = {1'b0, x[blk*CSEL_BLK +: CSEL_BLK]} + {1'b0, y[blk*CSEL_BLK +: CSEL_BLK]}
                 + (CSEL_BLK+1)'(1);
            r[blk*CSEL_BLK +: CSEL_BLK] = carry ? r1[CSEL_BLK-1:0] : r0[CSEL_BLK-1:0];
            carry                        = carry ? r1[CSEL_BLK] : r0[CSEL_BLK];
        end
        hi_sum = r[WIDTH-1:0] ^ {ctrl_q[STAGES].tc_mode, {(WIDTH-1){1'b0}}};
    end

    // All pipeline registers advance together on en; product only updates on a valid beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < STAGES; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
            end
            for (int s = 0; s <= STAGES; s++) ctrl_q[s] <= '0;
            for (int s = 1; s <= STAGES; s++) begin
                sum_q[s]   <= '0;
                carry_q[s] <= '0;
                lo_q[s]    <= '0;
            end
            out_valid <= 1'b0;
            product   <= '0;
            out_tag   <= '0;
        end else if (en) begin
            a_q[0]    <= a_in;
            b_q[0]    <= b_in;
            ctrl_q[0] <= '{valid: in_valid, tc_mode: tc_mode, tag: TAG_W_MAX'(in_tag)};
            for (int s = 1; s < STAGES; s++) begin
                a_q[s] <= a_q[s-1];
                b_q[s] <= b_q[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                sum_q[s+1]   <= sum_d[s];
                carry_q[s+1] <= carry_d[s];
                lo_q[s+1]    <= lo_d[s];
                ctrl_q[s+1]  <= ctrl_q[s];
            end
            out_valid <= ctrl_q[STAGES].valid;
            if (ctrl_q[STAGES].valid) begin
                product <= {hi_sum, lo_q[STAGES]};
                out_tag <= ctrl_q[STAGES].tag[TAG_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bw_mul_pipe.sv
// Directed bench for bw_mul_pipe at WIDTH=32, STAGES=4.
module tb_bw_mul_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int TAG_W  = 4;
    localparam int LAT    = STAGES + 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   a_in = '0;
    logic [WIDTH-1:0]   b_in = '0;
    logic               tc_mode = 1'b0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [2*WIDTH-1:0] product;
    logic [TAG_W-1:0]   out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        tc;
        logic [63:0] p;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC] = '{
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001},
        '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000},
        '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000},
        '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000},
        '{32'h80000000, 32'h00000001, 1'b0, 64'h0000000080000000},
        '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001},
        '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000},
        '{32'h7FFFFFFF, 32'h80000000, 1'b0, 64'h3FFFFFFF80000000},
        '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE},
        '{32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001FFFFFFFE},
        '{32'h12345678, 32'h00000010, 1'b1, 64'h0000000123456780},
        '{32'hFFFFFFF0, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFD0},
        '{32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000},
        '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000FFFE0001},
        '{32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h7FFFFFFF80000000},
        '{32'h00000003, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFF1},
        '{32'h00000001, 32'h80000000, 1'b1, 64'hFFFFFFFF80000000}
    };

    // Back-to-back beats: even slots unsigned, odd slots signed, same operand pair per couple.
    vec_t bb [8] = '{
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001},
        '{32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h7FFFFFFF80000000},
        '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000},
        '{32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001FFFFFFFE},
        '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE},
        '{32'hFFFFFFF0, 32'h00000003, 1'b0, 64'h00000002FFFFFFD0},
        '{32'hFFFFFFF0, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFD0}
    };

    bw_mul_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .tc_mode   (tc_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Single beat with out_ready held high: checks acceptance, latency, product and tag.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic tc,
                          input logic [3:0] tag, input logic [63:0] exp, input int id);
        int lat;
        bit seen;
        @(negedge clk);
        a_in = a; b_in = b; tc_mode = tc; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL op%0d_in_ready got=%b want=1", id, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = k + 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL op%0d_timeout no out_valid within 20 cycles", id);
        end else begin
            n_checks++;
            if (lat != LAT) begin
                n_fail++;
                $display("FAIL op%0d_latency got=%0d want=%0d", id, lat, LAT);
            end
            n_checks++;
            if (product !== exp) begin
                n_fail++;
                $display("FAIL op%0d_product got=%h want=%h", id, product, exp);
            end
            n_checks++;
            if (out_tag !== tag) begin
                n_fail++;
                $display("FAIL op%0d_tag got=%h want=%h", id, out_tag, tag);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL op%0d_single got out_valid=%b want=0", id, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        n_checks++;
        if (product !== 64'h0) begin n_fail++; $display("FAIL rst_product got=%h want=0", product); end
        n_checks++;
        if (out_tag !== 4'h0) begin n_fail++; $display("FAIL rst_out_tag got=%h want=0", out_tag); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].tc, 4'(i), vecs[i].p, i);
    endtask

    task automatic test_back_to_back();
        int  bi;
        int  oi;
        bit  acc;
        bit  exp_rdy;
        bit  exp_vld;
        bi = 0;
        oi = 0;
        @(negedge clk);
        for (int n = 0; n < 24; n++) begin
            out_ready = !(n >= 4 && n <= 9);
            if (bi < 8) begin
                a_in = bb[bi].a; b_in = bb[bi].b; tc_mode = bb[bi].tc;
                in_tag = 4'(bi); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_rdy = !(n >= 6 && n <= 9);
            exp_vld = (n >= 6 && n <= 17);
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_in_ready cycle=%0d got=%b want=%b", n, in_ready, exp_rdy);
            end
            n_checks++;
            if (out_valid !== exp_vld) begin
                n_fail++;
                $display("FAIL b2b_out_valid cycle=%0d got=%b want=%b", n, out_valid, exp_vld);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_checks++;
                if (oi >= 8) begin
                    n_fail++;
                    $display("FAIL b2b_extra cycle=%0d got product=%h want none", n, product);
                end else begin
                    if (product !== bb[oi].p) begin
                        n_fail++;
                        $display("FAIL b2b_product idx=%0d got=%h want=%h", oi, product, bb[oi].p);
                    end
                    n_checks++;
                    if (out_tag !== 4'(oi)) begin
                        n_fail++;
                        $display("FAIL b2b_tag idx=%0d got=%h want=%h", oi, out_tag, 4'(oi));
                    end
                end
                oi++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) bi++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (bi != 8) begin n_fail++; $display("FAIL b2b_accepted got=%0d want=8", bi); end
        n_checks++;
        if (oi != 8) begin n_fail++; $display("FAIL b2b_delivered got=%0d want=8", oi); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF; tc_mode = 1'b0;
            in_tag = 4'(i + 5); in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
        n_checks++;
        if (product !== 64'h0) begin n_fail++; $display("FAIL mid_rst_product got=%h want=0", product); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_post_valid cycle=%0d got=%b want=0", k, out_valid);
            end
            n_checks++;
            if (product !== 64'h0) begin
                n_fail++;
                $display("FAIL mid_post_product cycle=%0d got=%h want=0", k, product);
            end
        end
        run_op(32'h00000003, 32'h00000005, 1'b0, 4'hA, 64'h000000000000000F, 100);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
